// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - 640x480@60 timing defaults, colour widths and colour-bar table
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  localparam int unsigned VGA_RW = 3;
  localparam int unsigned VGA_GW = 3;
  localparam int unsigned VGA_BW = 2;

  // Bars left to right; result bit 2 = red on, bit 1 = green on, bit 0 = blue on.
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 3'b111;  // white
      3'd1:    bar_rgb = 3'b110;  // yellow
      3'd2:    bar_rgb = 3'b011;  // cyan
      3'd3:    bar_rgb = 3'b010;  // green
      3'd4:    bar_rgb = 3'b101;  // magenta
      3'd5:    bar_rgb = 3'b100;  // red
      3'd6:    bar_rgb = 3'b001;  // blue
      default: bar_rgb = 3'b000;  // black
    endcase
  endfunction

endpackage

// File: rtl/vga_if.sv
// rtl/vga_if.sv - pixel request / source colour / video output bundle
// master (generator): drives ce_pix, req, req_x, req_y, hs, vs, draw, r, g, b, frame;
//   receives src_r, src_g, src_b.
// slave (source + display side): the mirror image.
interface vga_if #(
  parameter int unsigned CNT_W = 10,
  parameter int unsigned RW    = 3,
  parameter int unsigned GW    = 3,
  parameter int unsigned BW    = 2
);
  logic             ce_pix;
  logic             req;
  logic [CNT_W-1:0] req_x;
  logic [CNT_W-1:0] req_y;
  logic [RW-1:0]    src_r;
  logic [GW-1:0]    src_g;
  logic [BW-1:0]    src_b;
  logic             hs;
  logic             vs;
  logic             draw;
  logic [RW-1:0]    r;
  logic [GW-1:0]    g;
  logic [BW-1:0]    b;
  logic             frame;

  modport master (
    output ce_pix, req, req_x, req_y, hs, vs, draw, r, g, b, frame,
    input  src_r, src_g, src_b
  );

  modport slave (
    input  ce_pix, req, req_x, req_y, hs, vs, draw, r, g, b, frame,
    output src_r, src_g, src_b
  );
endinterface

// File: rtl/vga_sync_pipe.sv
// rtl/vga_sync_pipe.sv - CE-gated N-stage delay line with synchronous reset
// Ports: clk, rst (sync, active-high), en (advance), din/dout (W bits).
// N = 0 degenerates to a wire.
module vga_sync_pipe #(
  parameter int unsigned N = 1,
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (N == 0) begin : g_wire
      assign dout = din;
    end else begin : g_pipe
      logic [W-1:0] stage_q [N];
      logic [W-1:0] stage_d [N];

      always_comb begin
        stage_d = stage_q;
        if (en) begin
          stage_d[0] = din;
          for (int i = 1; i < N; i++) stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < N; i++) stage_q[i] <= '0;
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[N-1];
    end
  endgenerate

endmodule

// File: rtl/vga_frame_gen.sv
// rtl/vga_frame_gen.sv - VGA frame generator: pixel divider, H/V counters, source request, aligned output stage
// Ports: clk, rst (sync, active-high); bus (vga_if.master): pixel request out, source colour in,
//   synced and blanked video out, frame-start strobe.
// Build option VGA_TEST_PATTERN_EN: eight internal colour bars replace the source colour.
module vga_frame_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned SRC_LAT  = 1,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned RW       = VGA_RW,
  parameter int unsigned GW       = VGA_GW,
  parameter int unsigned BW       = VGA_BW
) (
  input logic   clk,
  input logic   rst,
  vga_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // The column only travels down the delay line when the bar pattern needs it.
`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned PW = 3 + CNT_W;
`else
  localparam int unsigned PW = 3;
`endif

  logic [DIV_W-1:0] div_q, div_d;
  logic             ce_q, ce_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             vis, hs_raw, vs_raw;
  logic [PW-1:0]    pipe_in, pipe_out;
  logic             hs_dl, vs_dl, vis_dl;
  logic [RW-1:0]    pix_r, r_q, r_d;
  logic [GW-1:0]    pix_g, g_q, g_d;
  logic [BW-1:0]    pix_b, b_q, b_d;
  logic             hs_q, hs_d, vs_q, vs_d, draw_q, draw_d;

  // ce is registered so it reads 0 in reset even when CLK_DIV = 1.
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    ce_d  = (div_q == DIV_LAST);
    h_d   = h_q;
    v_d   = v_q;
    if (ce_q) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  assign vis    = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_raw = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_raw = (v_q >= VS_BEG) && (v_q < VS_END);

`ifdef VGA_TEST_PATTERN_EN
  assign pipe_in = {h_q, hs_raw, vs_raw, vis};
`else
  assign pipe_in = {hs_raw, vs_raw, vis};
`endif

  // SRC_LAT stages here plus the output register give SRC_LAT+1 ticks total.
  vga_sync_pipe #(.N(SRC_LAT), .W(PW)) u_sync_pipe (
    .clk  (clk),
    .rst  (rst),
    .en   (ce_q),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  assign {hs_dl, vs_dl, vis_dl} = pipe_out[2:0];

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;
  logic [CNT_W-1:0] x_dl;
  logic [2:0]       bar_idx, bar_on;

  assign x_dl = pipe_out[PW-1:3];

  // Threshold compare instead of a divide by a non-power-of-two bar width.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x_dl >= CNT_W'(i * BAR_W)) bar_idx = 3'(i);
    end
  end

  assign bar_on = bar_rgb(bar_idx);
  assign pix_r  = {RW{bar_on[2]}};
  assign pix_g  = {GW{bar_on[1]}};
  assign pix_b  = {BW{bar_on[0]}};
`else
  assign pix_r = bus.src_r;
  assign pix_g = bus.src_g;
  assign pix_b = bus.src_b;
`endif

  always_comb begin
    hs_d   = hs_q;
    vs_d   = vs_q;
    draw_d = draw_q;
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    if (ce_q) begin
      hs_d   = hs_dl ? HS_POL : ~HS_POL;
      vs_d   = vs_dl ? VS_POL : ~VS_POL;
      draw_d = vis_dl;
      r_d    = vis_dl ? pix_r : '0;
      g_d    = vis_dl ? pix_g : '0;
      b_d    = vis_dl ? pix_b : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      ce_q   <= 1'b0;
      h_q    <= '0;
      v_q    <= '0;
      hs_q   <= ~HS_POL;
      vs_q   <= ~VS_POL;
      draw_q <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      div_q  <= div_d;
      ce_q   <= ce_d;
      h_q    <= h_d;
      v_q    <= v_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      draw_q <= draw_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign bus.ce_pix = ce_q;
  assign bus.req    = ce_q & vis;
  assign bus.req_x  = h_q;
  assign bus.req_y  = v_q;
  assign bus.frame  = ce_q & (h_q == '0) & (v_q == '0);
  assign bus.hs     = hs_q;
  assign bus.vs     = vs_q;
  assign bus.draw   = draw_q;
  assign bus.r      = r_q;
  assign bus.g      = g_q;
  assign bus.b      = b_q;

endmodule
